// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end.
// Holds the FSM state and phase encodings, RAM command codes and default widths.
package spi_pkg;

    localparam int DIN_W_DEF       = 10;
    localparam int DOUT_W_DEF      = 8;
    localparam int RD_WAIT_MAX_DEF = 4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // Sub-phase inside WRITE/READ_ADD/READ_DATA
    typedef enum logic [1:0] {
        PH_SHIFT,
        PH_WAIT,
        PH_OUT,
        PH_HOLD
    } phase_t;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Pin/RAM-side bundle of the SPI slave front-end.
// slave: the controller (SS_n, MOSI, tx_* in; MISO, rx_* out); master: the driver side.
interface spi_slave_ctrl_if
    import spi_pkg::*;
#(
    parameter int DW = DIN_W_DEF,
    parameter int OW = DOUT_W_DEF
);
    logic          SS_n;
    logic          MOSI;
    logic          MISO;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [OW-1:0] tx_data;
    logic          tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_piso.sv
// Parallel-load, shift-out register that sources MISO (MSB first).
// Ports: clk, rst_n, clr, load, shift, din[W], dout (registered, 0 when idle).
module spi_piso
    import spi_pkg::*;
#(
    parameter int W = DOUT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] sreg;

    // dout falls back to 0 on any cycle that neither loads nor shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            dout <= 1'b0;
        end else if (clr) begin
            sreg <= '0;
            dout <= 1'b0;
        end else if (load) begin
            dout <= din[W-1];
            sreg <= {din[W-2:0], 1'b0};
        end else if (shift) begin
            dout <= sreg[W-1];
            sreg <= {sreg[W-2:0], 1'b0};
        end else begin
            dout <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises 10-bit command words for the RAM and
// serialises RAM read data on MISO. Ports: clk, rst_n, bus (slave modport).
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int DIN_W       = DIN_W_DEF,
    parameter int DOUT_W      = DOUT_W_DEF,
    parameter int RD_WAIT_MAX = RD_WAIT_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_slave_ctrl_if.slave        bus
);

    localparam int CNT_W = $clog2(DIN_W + DOUT_W + RD_WAIT_MAX);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DIN_W - 2);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(DOUT_W - 1);

    state_t           state;
    state_t           state_nx;
    phase_t           phase;
    phase_t           phase_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [DIN_W-1:0] sipo;
    logic [DIN_W-1:0] rx_word;
    logic             rx_strobe;
    logic             rd_addr_flag;
    logic             miso;

    logic active;
    logic shift_in;
    logic rx_load;
    logic flag_set;
    logic flag_clr;
    logic piso_load;
    logic piso_shift;

    // A frame is live only while selected and out of IDLE
    assign active = (state != IDLE) && !bus.SS_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!bus.SS_n) state_nx = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n)          state_nx = IDLE;
                else if (!bus.MOSI)    state_nx = WRITE;
                else if (rd_addr_flag) state_nx = READ_DATA;
                else                   state_nx = READ_ADD;
            end
            default: begin
                if (bus.SS_n) state_nx = IDLE;
            end
        endcase
    end

    // cnt is reused: bits shifted in, wait cycles, then bits shifted out
    always_comb begin
        shift_in   = 1'b0;
        rx_load    = 1'b0;
        flag_set   = 1'b0;
        flag_clr   = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        phase_nx   = phase;
        cnt_nx     = cnt;
        if (!active) begin
            phase_nx = PH_SHIFT;
            cnt_nx   = '0;
        end else if (state == CHK_CMD) begin
            shift_in = 1'b1;
        end else begin
            unique case (phase)
                PH_SHIFT: begin
                    if (cnt <= LAST_BIT) begin
                        shift_in = 1'b1;
                        cnt_nx   = cnt + 1'b1;
                    end else begin
                        rx_load  = 1'b1;
                        cnt_nx   = '0;
                        flag_set = (state == READ_ADD);
                        phase_nx = (state == READ_DATA) ? PH_WAIT : PH_HOLD;
                    end
                end
                PH_WAIT: begin
                    if (bus.tx_valid) begin
                        piso_load = 1'b1;
                        cnt_nx    = '0;
                        phase_nx  = PH_OUT;
                    end else if (cnt == WAIT_LAST) begin
                        cnt_nx    = '0;
                        phase_nx  = PH_HOLD;
                    end else begin
                        cnt_nx    = cnt + 1'b1;
                    end
                end
                PH_OUT: begin
                    if (cnt != OUT_LAST) begin
                        piso_shift = 1'b1;
                        cnt_nx     = cnt + 1'b1;
                    end else begin
                        flag_clr   = 1'b1;
                        cnt_nx     = '0;
                        phase_nx   = PH_HOLD;
                    end
                end
                PH_HOLD: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= PH_SHIFT;
            cnt          <= '0;
            sipo         <= '0;
            rx_word      <= '0;
            rx_strobe    <= 1'b0;
            rd_addr_flag <= 1'b0;
        end else begin
            phase     <= phase_nx;
            cnt       <= cnt_nx;
            rx_strobe <= rx_load;
            if (shift_in) sipo    <= {sipo[DIN_W-2:0], bus.MOSI};
            if (rx_load)  rx_word <= sipo;
            if (flag_set)      rd_addr_flag <= 1'b1;
            else if (flag_clr) rd_addr_flag <= 1'b0;
        end
    end

    spi_piso #(
        .W(DOUT_W)
    ) u_piso (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!active),
        .load (piso_load),
        .shift(piso_shift),
        .din  (bus.tx_data),
        .dout (miso)
    );

    assign bus.MISO     = miso;
    assign bus.rx_data  = rx_word;
    assign bus.rx_valid = rx_strobe;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: frames driven on the falling edge,
// outputs sampled on the falling edge, expectations hand-computed.
module tb_spi_slave_ctrl;
    import spi_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    logic [9:0] last_word = '0;

    spi_slave_ctrl_if bus ();

    spi_slave_ctrl dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($isunknown(bus.rx_valid)) begin
                fails++;
                $display("FAIL rx_valid_x: got %b want 0/1", bus.rx_valid);
            end
        end
    end

    task automatic frame(input logic [9:0] w);
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            if (bus.rx_valid !== 1'b0) bad = 1'b1;
            bus.MOSI = w[i];
        end
        @(negedge clk);
        if (bus.rx_valid !== 1'b0) bad = 1'b1;
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL early_rx_valid: got 1 want 0 (word %h)", w);
        end
        @(negedge clk);
        checks++;
        if (bus.rx_valid !== 1'b1) begin
            fails++;
            $display("FAIL rx_valid: got %b want 1 (word %h)", bus.rx_valid, w);
        end
        checks++;
        if (bus.rx_data !== w) begin
            fails++;
            $display("FAIL rx_data: got %h want %h", bus.rx_data, w);
        end
        last_word = w;
    endtask

    task automatic end_frame();
        @(negedge clk);
        checks++;
        if (bus.rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL rx_valid_width: got %b want 0", bus.rx_valid);
        end
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_flag(input logic want, input string name);
        checks++;
        if (dut.rd_addr_flag !== want) begin
            fails++;
            $display("FAIL %s: flag got %b want %b", name, dut.rd_addr_flag, want);
        end
    endtask

    task automatic read_data_frame(input logic [9:0] w, input logic [7:0] d,
                                   input int delay);
        logic bad;
        bad = 1'b0;
        frame(w);
        repeat (delay) begin
            @(negedge clk);
            if (bus.MISO !== 1'b0) bad = 1'b1;
        end
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            bus.tx_valid = 1'b0;
            bus.tx_data  = '0;
            checks++;
            if (bus.MISO !== d[i]) begin
                fails++;
                $display("FAIL miso_bit%0d: got %b want %b", i, bus.MISO, d[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bad || bus.MISO !== 1'b0) begin
            fails++;
            $display("FAIL miso_idle: got %b want 0", bus.MISO);
        end
        check_flag(1'b0, "flag_clear");
        end_frame();
    endtask

    task automatic test_reset();
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.MISO !== 1'b0 || bus.rx_valid !== 1'b0 || bus.rx_data !== 10'h000) begin
            fails++;
            $display("FAIL reset_out: got miso=%b rv=%b rd=%h want 0 0 000",
                     bus.MISO, bus.rx_valid, bus.rx_data);
        end
        checks++;
        if (dut.state !== IDLE) begin
            fails++;
            $display("FAIL reset_state: got %0d want IDLE", dut.state);
        end
        check_flag(1'b0, "reset_flag");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        frame(10'h005);
        end_frame();
        frame(10'h1AA);
        end_frame();
        check_flag(1'b0, "write_flag");
    endtask

    task automatic test_read();
        frame(10'h205);
        check_flag(1'b1, "rd_addr_set");
        end_frame();
        read_data_frame(10'h3C3, 8'hAA, 1);
    endtask

    task automatic test_rd_no_addr();
        logic bad;
        bad = 1'b0;
        frame(10'h333);
        check_flag(1'b1, "rd_no_addr_flag");
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        repeat (12) begin
            @(negedge clk);
            if (bus.MISO !== 1'b0) bad = 1'b1;
        end
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL rd_add_miso: got activity want 0");
        end
        end_frame();
        read_data_frame(10'h3A5, 8'h5C, 0);
    endtask

    task automatic test_abort();
        logic bad;
        logic [9:0] w;
        logic [9:0] prev;
        bad  = 1'b0;
        w    = 10'h0F5;
        prev = last_word;
        @(negedge clk);
        bus.SS_n = 1'b0;
        for (int i = 9; i >= 5; i--) begin
            @(negedge clk);
            bus.MOSI = w[i];
        end
        @(negedge clk);
        bus.SS_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.rx_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL abort_rx_valid: got 1 want 0");
        end
        checks++;
        if (bus.rx_data !== prev) begin
            fails++;
            $display("FAIL abort_hold: got %h want %h", bus.rx_data, prev);
        end
        frame(w);
        end_frame();
    endtask

    task automatic test_timeout();
        logic bad;
        bad = 1'b0;
        frame(10'h2AB);
        end_frame();
        frame(10'h3CC);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (bus.MISO !== 1'b0) bad = 1'b1;
            bus.tx_valid = (j == 3);
            bus.tx_data  = (j == 3) ? 8'hFF : 8'h00;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL timeout_miso: got activity want 0");
        end
        check_flag(1'b1, "timeout_flag");
        end_frame();
        read_data_frame(10'h381, 8'h81, 3);
    endtask

    task automatic test_spurious();
        logic bad;
        bad = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        frame(10'h1F0);
        repeat (6) begin
            @(negedge clk);
            if (bus.MISO !== 1'b0) bad = 1'b1;
        end
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL spurious_miso: got activity want 0");
        end
        end_frame();
        check_flag(1'b0, "spurious_flag");
    endtask

    task automatic test_reset_mid();
        frame(10'h2C3);
        end_frame();
        frame(10'h3C3);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            bus.tx_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.MISO !== 1'b0 || bus.rx_valid !== 1'b0 || bus.rx_data !== 10'h000) begin
            fails++;
            $display("FAIL mid_reset_out: got miso=%b rv=%b rd=%h want 0 0 000",
                     bus.MISO, bus.rx_valid, bus.rx_data);
        end
        check_flag(1'b0, "mid_reset_flag");
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dut.state !== IDLE) begin
            fails++;
            $display("FAIL mid_reset_state: got %0d want IDLE", dut.state);
        end
        rst_n = 1'b1;
        frame(10'h3E7);
        check_flag(1'b1, "post_reset_decode");
        end_frame();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_rd_no_addr();
        test_abort();
        test_timeout();
        test_spurious();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
